memory_read_tx: RTL and testbench



---
 rtl/memory_read_tx_if.sv | 41 ++++
 rtl/memory_read_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_memory_read_tx.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_read_tx_if.sv
// memory_read_tx_if
// Bundles the two byte/word buses that memory_read_tx sits between:
// the instruction-RAM read port and the UART transmitter byte interface.
//
// Signals:
//   ram_re    RAM read enable, one-cycle pulse per word  (master -> slave)
//   ram_ra    RAM read address                           (master -> slave)
//   ram_dout  RAM read data, valid RD_LAT clocks later   (slave  -> master)
//   tx_start  one-cycle request to send tx_data          (master -> slave)
//   tx_data   byte to send, stable until tx_done         (master -> slave)
//   tx_done   one-cycle pulse when the byte has gone     (slave  -> master)
//
// master: the dump engine.  slave: the RAM/UART side.
interface memory_read_tx_if #(
  parameter int ADDR_W = 8
);
  logic              ram_re;
  logic [ADDR_W-1:0] ram_ra;
  logic [15:0]       ram_dout;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;

  modport master (
    output ram_re,
    output ram_ra,
    output tx_start,
    output tx_data,
    input  ram_dout,
    input  tx_done
  );

  modport slave (
    input  ram_re,
    input  ram_ra,
    input  tx_start,
    input  tx_data,
    output ram_dout,
    output tx_done
  );
endinterface

// File: rtl/memory_read_tx.sv
// memory_read_tx
// Dumps an inclusive, possibly wrapping, range of the 16-bit instruction
// RAM out over the UART transmitter, high byte first, two bytes per word.
// Counterpart of the UART-receive / memory-write loader path.
//
// Parameters:
//   ADDR_W  instruction RAM address width
//   RD_LAT  RAM read latency in clocks from ram_re to valid ram_dout (1..3)
//
// Ports:
//   clk         system clock (100 MHz)
//   rst         asynchronous, active-low reset
//   start       single-cycle dump request, honoured only in IDLE
//   first_addr  first word address, captured on accepted start
//   last_addr   last word address (inclusive), captured on accepted start
//   bus         memory_read_tx_if.master: RAM read port + UART tx bytes
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse after the final byte's tx_done
//
// Optional build macro:
//   MEMORY_READ_TX_CHECKSUM_EN  append an 8-bit checksum byte (sum mod 256
//                               of every data byte of the dump) before done.
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; all outputs quiet
// S_READ    | ram_re pulse at ram_ra = addr
// S_WAIT    | RD_LAT-cycle read latency down-count, then latch word
// S_SEND_HI | tx_start pulse with the high byte
// S_WAIT_HI | high byte on the wire, wait for tx_done
// S_SEND_LO | tx_start pulse with the low byte
// S_WAIT_LO | low byte on the wire, wait for tx_done
// S_NEXT    | end-of-range test, else advance addr (wraps)
// S_SEND_CS | tx_start pulse with the checksum (checksum build only)
// S_WAIT_CS | checksum on the wire, wait for tx_done (checksum build only)
// S_DONE    | done pulse, busy already low
module memory_read_tx #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  memory_read_tx_if.master  bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_READ    = 4'd1,
    S_WAIT    = 4'd2,
    S_SEND_HI = 4'd3,
    S_WAIT_HI = 4'd4,
    S_SEND_LO = 4'd5,
    S_WAIT_LO = 4'd6,
    S_NEXT    = 4'd7,
`ifdef MEMORY_READ_TX_CHECKSUM_EN
    S_SEND_CS = 4'd8,
    S_WAIT_CS = 4'd9,
`endif
    S_DONE    = 4'd10
  } state_t;

  // The latency counter runs down to zero; it is loaded in READ so the
  // WAIT state lasts exactly RD_LAT cycles and samples ram_dout on the last.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] end_addr;
  logic [15:0]       word;
  logic [1:0]        lat_cnt;
  logic              lat_tc;
  logic              last_word;

  logic              ram_re_c;
  logic              tx_start_c;
  logic [7:0]        tx_data_c;
  logic              busy_c;
  logic              done_c;

`ifdef MEMORY_READ_TX_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign lat_tc    = (lat_cnt == 2'd0);
  assign last_word = (addr == end_addr);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state;
    ram_re_c   = 1'b0;
    tx_start_c = 1'b0;
    tx_data_c  = 8'h00;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (start) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        ram_re_c  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (lat_tc) begin
          state_nxt = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        tx_data_c  = word[15:8];
        tx_start_c = 1'b1;
        state_nxt  = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        tx_data_c = word[15:8];
        if (bus.tx_done) begin
          state_nxt = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        tx_data_c  = word[7:0];
        tx_start_c = 1'b1;
        state_nxt  = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        tx_data_c = word[7:0];
        if (bus.tx_done) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_word) begin
`ifdef MEMORY_READ_TX_CHECKSUM_EN
          state_nxt = S_SEND_CS;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_READ;
        end
      end
`ifdef MEMORY_READ_TX_CHECKSUM_EN
      S_SEND_CS: begin
        tx_data_c  = csum;
        tx_start_c = 1'b1;
        state_nxt  = S_WAIT_CS;
      end
      S_WAIT_CS: begin
        tx_data_c = csum;
        if (bus.tx_done) begin
          state_nxt = S_DONE;
        end
      end
`endif
      S_DONE: begin
        busy_c    = 1'b0;
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_c    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address range, read latency and word capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      end_addr <= '0;
      word     <= 16'h0000;
      lat_cnt  <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr     <= first_addr;
            end_addr <= last_addr;
          end
        end
        S_READ: begin
          lat_cnt <= LAT_INIT;
        end
        S_WAIT: begin
          if (lat_tc) begin
            word <= bus.ram_dout;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_NEXT: begin
          // Natural ADDR_W-bit overflow gives the wrap through zero.
          if (!last_word) begin
            addr <= addr + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEMORY_READ_TX_CHECKSUM_EN
  // Running byte sum, accumulated as each data byte is handed to the UART.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= 8'h00;
    end else if (state == S_IDLE && start) begin
      csum <= 8'h00;
    end else if (state == S_SEND_HI || state == S_SEND_LO) begin
      csum <= csum + tx_data_c;
    end
  end
`endif

  assign bus.ram_re   = ram_re_c;
  assign bus.ram_ra   = addr;
  assign bus.tx_start = tx_start_c;
  assign bus.tx_data  = tx_data_c;
  assign busy         = busy_c;
  assign done         = done_c;

endmodule

// File: tb/tb_memory_read_tx.sv
module tb_memory_read_tx;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;
  localparam int UART_T = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              busy;
  logic              done;
  logic              uart_done = 1'b0;
  logic              stray_done = 1'b0;
  logic              uart_busy = 1'b0;

  logic [15:0]       mem [256];
  logic [7:0]        tx_q[$];
  logic [7:0]        rd_q[$];
  int                done_cnt = 0;
  int                n_checks = 0;
  int                n_errors = 0;

  memory_read_tx_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.tx_done = uart_done | stray_done;

  memory_read_tx #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model: registered read with RD_LAT cycles of latency.
  initial begin
    logic [7:0] a;
    bus.ram_dout = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.ram_re === 1'b1) begin
        a = bus.ram_ra;
        repeat (RD_LAT) @(posedge clk);
        #1 bus.ram_dout = mem[a];
      end
    end
  end

  // Monitor: read addresses and done pulses.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1) begin
      if (bus.ram_re === 1'b1) rd_q.push_back(bus.ram_ra);
      if (done === 1'b1) done_cnt++;
    end
  end

  // UART model: accepts a byte, checks it stays put, answers with tx_done.
  initial begin
    logic [7:0] b;
    forever begin
      if (rst === 1'b1 && bus.tx_start === 1'b1) begin
        b = bus.tx_data;
        tx_q.push_back(b);
        uart_busy = 1'b1;
        for (int i = 0; i < UART_T; i++) begin
          @(negedge clk);
          if (rst !== 1'b1) break;
          check("tx_data_stable", bus.tx_data, b);
        end
        if (rst === 1'b1) begin
          uart_done = 1'b1;
          @(negedge clk);
          uart_done = 1'b0;
        end
        uart_busy = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic clear_logs();
    tx_q.delete();
    rd_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_dump(input logic [7:0] f, input logic [7:0] l);
    @(negedge clk);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    check("busy_before_accept", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("uart_idle_at_done", uart_busy, 1'b0);
    @(negedge clk);
    check("done_width", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic expect_results(input logic [7:0] exp_b[$], input logic [7:0] exp_r[$]);
    logic [7:0] eb[$];
`ifdef MEMORY_READ_TX_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
    foreach (exp_b[i]) sum = sum + exp_b[i];
`endif
    eb = exp_b;
`ifdef MEMORY_READ_TX_CHECKSUM_EN
    eb.push_back(sum);
`endif
    check("byte_count", tx_q.size(), eb.size());
    foreach (eb[i]) begin
      if (i < tx_q.size()) check($sformatf("tx_byte%0d", i), tx_q[i], eb[i]);
    end
    check("read_count", rd_q.size(), exp_r.size());
    foreach (exp_r[i]) begin
      if (i < rd_q.size()) check($sformatf("read_addr%0d", i), rd_q[i], exp_r[i]);
    end
    check("done_count", done_cnt, 1);
  endtask

  initial begin
    logic [7:0] eb[$];
    logic [7:0] er[$];
    int n;

    foreach (mem[i]) mem[i] = 16'h0000;
    mem[8'h10] = 16'hA55A;
    mem[8'h00] = 16'h0102;
    mem[8'h01] = 16'h0304;
    mem[8'h02] = 16'h0506;
    mem[8'h03] = 16'h0708;
    mem[8'hFE] = 16'hDEAD;
    mem[8'hFF] = 16'hBEEF;

    // Reset values.
    #22;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ram_re", bus.ram_re, 1'b0);
    check("rst_ram_ra", bus.ram_ra, 8'h00);
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, first == last.
    clear_logs();
    run_dump(8'h10, 8'h10);
    wait_done(200);
    eb = {8'hA5, 8'h5A};
    er = {8'h10};
    expect_results(eb, er);

    // Four words in order.
    clear_logs();
    run_dump(8'h00, 8'h03);
    wait_done(400);
    eb = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    er = {8'h00, 8'h01, 8'h02, 8'h03};
    expect_results(eb, er);

    // Wrapping range 0xFE..0x01.
    clear_logs();
    run_dump(8'hFE, 8'h01);
    wait_done(400);
    eb = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    er = {8'hFE, 8'hFF, 8'h00, 8'h01};
    expect_results(eb, er);

    // Stray tx_done during WAIT and start during WAIT_HI are ignored.
    clear_logs();
    run_dump(8'h00, 8'h01);
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_tx_start_seen", bus.tx_start, 1'b1);
    @(negedge clk);
    first_addr = 8'h40;
    last_addr  = 8'h40;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_ignored_start", busy, 1'b1);
    wait_done(300);
    eb = {8'h01, 8'h02, 8'h03, 8'h04};
    er = {8'h00, 8'h01};
    expect_results(eb, er);

    // Async reset in WAIT_LO of the second word, then a fresh dump.
    clear_logs();
    run_dump(8'h00, 8'h03);
    n = 0;
    while (tx_q.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_word2_lo", (tx_q.size() >= 4), 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ram_re", bus.ram_re, 1'b0);
    check("mid_rst_ram_ra", bus.ram_ra, 8'h00);
    check("mid_rst_tx_start", bus.tx_start, 1'b0);
    check("mid_rst_tx_data", bus.tx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_logs();
    run_dump(8'h10, 8'h10);
    wait_done(200);
    eb = {8'hA5, 8'h5A};
    er = {8'h10};
    expect_results(eb, er);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
